// File: rtl/mem_port_arbiter.sv
// Shares one combinational-read / clocked-write main memory between the fetch port and the
// load/store port. Data wins by default, and fetch gets forced priority after MAX_STALL refusals.
module mem_port_arbiter #(
    parameter int MAX_STALL = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    input  logic [31:0] mem_data_out
);

    localparam int              SC_W   = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(MAX_STALL);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SC_W-1:0]   sc;
    logic [31:0]       rmw_word_p1;
    logic              capture;
    logic              fetch_force;
    logic              fetch_win;
    logic              data_win;
    logic [31:0]       addr_aligned;

    // Replace the byte or half-word lane at byte offset 'off' of 'word' with the low bits of 'wdata'.
    function automatic logic [31:0] merge_lane(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  off,
        input logic        half
    );
        logic [31:0] mask;
        logic [4:0]  sh;
        mask = half ? 32'h0000_FFFF : 32'h0000_00FF;
        sh   = {off, 3'b000};
        return (word & ~(mask << sh)) | ((wdata & mask) << sh);
    endfunction

    assign fetch_force  = (sc == SC_MAX);
    assign fetch_win    = if_req & (fetch_force | ~d_req);
    assign data_win     = d_req & ~fetch_win;
    assign addr_aligned = {d_addr[31:2], 2'b00};
    assign if_rdata     = mem_data_out;
    assign d_rdata      = mem_data_out;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            sc          <= '0;
            rmw_word_p1 <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                rmw_word_p1 <= mem_data_out;
            end
            if (if_gnt || !if_req) begin
                sc <= '0;
            end else if (sc != SC_MAX) begin
                sc <= sc + SC_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        capture        = 1'b0;
        if_gnt         = 1'b0;
        d_gnt          = 1'b0;
        d_err          = 1'b0;
        mem_read_write = 1'b0;
        mem_address    = if_addr;
        mem_data_in    = '0;

        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (fetch_win) begin
                        if_gnt = 1'b1;
                    end else if (data_win) begin
                        mem_address = d_addr;
                        if (!d_we) begin
                            d_gnt = 1'b1;
                        end else if (d_size[1]) begin
                            mem_data_in    = d_wdata;
                            mem_read_write = 1'b1;
                            d_gnt          = 1'b1;
                        end else if (d_size[0] && d_addr[0]) begin
                            d_gnt = 1'b1;
                            d_err = 1'b1;
                        end else begin
                            // Sub-word store, read phase: fetch the aligned word to merge into.
                            mem_address = addr_aligned;
                            capture     = 1'b1;
                            state_nxt   = RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    // Write phase: request inputs are still held, so the lane comes straight from them.
                    mem_address    = addr_aligned;
                    mem_data_in    = merge_lane(rmw_word_p1, d_wdata, d_addr[1:0], d_size[0]);
                    mem_read_write = 1'b1;
                    d_gnt          = 1'b1;
                    state_nxt      = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-addressed memory behind the arbiter.
// Expected values are hand-computed constants.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read_write;
    logic [31:0] mem_data_out;

    int n_checks;
    int n_fail;

    mem_port_arbiter #(.MAX_STALL(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_gnt         (if_gnt),
        .if_rdata       (if_rdata),
        .d_req          (d_req),
        .d_addr         (d_addr),
        .d_we           (d_we),
        .d_size         (d_size),
        .d_wdata        (d_wdata),
        .d_gnt          (d_gnt),
        .d_rdata        (d_rdata),
        .d_err          (d_err),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_read_write (mem_read_write),
        .mem_data_out   (mem_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory window at 0x01000000: combinational little-endian read, clocked write.
    logic [7:0] mem [0:255];
    logic [7:0] moff;
    assign moff = mem_address[7:0];

    always_comb begin
        mem_data_out = {mem[8'(moff + 8'd3)], mem[8'(moff + 8'd2)],
                        mem[8'(moff + 8'd1)], mem[moff]};
    end

    always @(posedge clock) begin
        if (mem_read_write) begin
            mem[moff]              <= mem_data_in[7:0];
            mem[8'(moff + 8'd1)]   <= mem_data_in[15:8];
            mem[8'(moff + 8'd2)]   <= mem_data_in[23:16];
            mem[8'(moff + 8'd3)]   <= mem_data_in[31:24];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_d(input logic req, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        d_req   = req;
        d_we    = we;
        d_size  = size;
        d_addr  = addr;
        d_wdata = wdata;
    endtask

    // Outputs are sampled on the falling edge; inputs change just after the rising edge.
    task automatic to_sample();
        @(negedge clock);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        if_req   = 1'b1;
        if_addr  = 32'h0100_0000;
        set_d(1'b1, 1'b0, 2'd2, 32'h0100_0010, 32'h0);

        // Reset held two cycles with both requesting
        for (int i = 0; i < 2; i++) begin
            to_sample();
            check("rst_if_gnt", 32'(if_gnt), 32'd0);
            check("rst_d_gnt", 32'(d_gnt), 32'd0);
            check("rst_rw", 32'(mem_read_write), 32'd0);
            check("rst_addr", mem_address, 32'h0100_0000);
            next_cycle();
        end
        reset = 1'b0;
        to_sample();
        check("first_d_gnt", 32'(d_gnt), 32'd1);
        check("first_if_gnt", 32'(if_gnt), 32'd0);
        next_cycle();
        if_req = 1'b0;
        set_d(1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
        next_cycle();

        // Seed 0x00000513 at 0x01000000, then fetch it
        set_d(1'b1, 1'b1, 2'd2, 32'h0100_0000, 32'h0000_0513);
        to_sample();
        check("seed_d_gnt", 32'(d_gnt), 32'd1);
        check("seed_rw", 32'(mem_read_write), 32'd1);
        check("seed_wdata", mem_data_in, 32'h0000_0513);
        next_cycle();
        set_d(1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
        if_req  = 1'b1;
        if_addr = 32'h0100_0000;
        to_sample();
        check("fetch_gnt", 32'(if_gnt), 32'd1);
        check("fetch_d_gnt", 32'(d_gnt), 32'd0);
        check("fetch_rdata", if_rdata, 32'h0000_0513);
        next_cycle();
        if_req = 1'b0;

        // Word store then load
        set_d(1'b1, 1'b1, 2'd2, 32'h0100_0010, 32'hDEAD_BEEF);
        to_sample();
        check("sw_d_gnt", 32'(d_gnt), 32'd1);
        next_cycle();
        set_d(1'b1, 1'b0, 2'd2, 32'h0100_0010, 32'h0);
        to_sample();
        check("lw_d_gnt", 32'(d_gnt), 32'd1);
        check("lw_rdata", d_rdata, 32'hDEAD_BEEF);
        next_cycle();

        // Sub-word stores
        set_d(1'b1, 1'b1, 2'd2, 32'h0100_0020, 32'h1122_3344);
        next_cycle();
        set_d(1'b1, 1'b1, 2'd0, 32'h0100_0022, 32'h0000_00AA);
        to_sample();
        check("sb_c1_d_gnt", 32'(d_gnt), 32'd0);
        check("sb_c1_rw", 32'(mem_read_write), 32'd0);
        check("sb_c1_addr", mem_address, 32'h0100_0020);
        next_cycle();
        to_sample();
        check("sb_c2_d_gnt", 32'(d_gnt), 32'd1);
        check("sb_c2_rw", 32'(mem_read_write), 32'd1);
        check("sb_c2_wdata", mem_data_in, 32'h11AA_3344);
        next_cycle();
        set_d(1'b1, 1'b0, 2'd2, 32'h0100_0020, 32'h0);
        to_sample();
        check("sb_reload", d_rdata, 32'h11AA_3344);
        next_cycle();

        set_d(1'b1, 1'b1, 2'd1, 32'h0100_0020, 32'h0000_BEEF);
        to_sample();
        check("sh_c1_d_gnt", 32'(d_gnt), 32'd0);
        next_cycle();
        to_sample();
        check("sh_c2_d_gnt", 32'(d_gnt), 32'd1);
        next_cycle();
        set_d(1'b1, 1'b0, 2'd2, 32'h0100_0020, 32'h0);
        to_sample();
        check("sh_reload", d_rdata, 32'h11AA_BEEF);
        next_cycle();

        set_d(1'b1, 1'b1, 2'd1, 32'h0100_0021, 32'h0000_1234);
        to_sample();
        check("mis_d_gnt", 32'(d_gnt), 32'd1);
        check("mis_d_err", 32'(d_err), 32'd1);
        check("mis_rw", 32'(mem_read_write), 32'd0);
        next_cycle();
        set_d(1'b1, 1'b0, 2'd2, 32'h0100_0020, 32'h0);
        to_sample();
        check("mis_reload", d_rdata, 32'h11AA_BEEF);
        check("load_no_err", 32'(d_err), 32'd0);
        next_cycle();

        // Starvation guard: data held continuously alongside fetch
        set_d(1'b1, 1'b0, 2'd2, 32'h0100_0010, 32'h0);
        if_req  = 1'b1;
        if_addr = 32'h0100_0000;
        for (int i = 0; i < 4; i++) begin
            to_sample();
            check($sformatf("stall%0d_if_gnt", i), 32'(if_gnt), 32'd0);
            check($sformatf("stall%0d_d_gnt", i), 32'(d_gnt), 32'd1);
            next_cycle();
        end
        to_sample();
        check("force_if_gnt", 32'(if_gnt), 32'd1);
        check("force_d_gnt", 32'(d_gnt), 32'd0);
        check("force_rdata", if_rdata, 32'h0000_0513);
        next_cycle();
        to_sample();
        check("post_force_d_gnt", 32'(d_gnt), 32'd1);
        check("post_force_if_gnt", 32'(if_gnt), 32'd0);
        next_cycle();
        if_req = 1'b0;

        // Reset during the write phase of a byte store
        set_d(1'b1, 1'b1, 2'd0, 32'h0100_0020, 32'h0000_0055);
        to_sample();
        check("abort_c1_d_gnt", 32'(d_gnt), 32'd0);
        next_cycle();
        reset = 1'b1;
        to_sample();
        check("abort_rw", 32'(mem_read_write), 32'd0);
        check("abort_d_gnt", 32'(d_gnt), 32'd0);
        next_cycle();
        reset = 1'b0;
        set_d(1'b1, 1'b0, 2'd2, 32'h0100_0020, 32'h0);
        to_sample();
        check("abort_idle_d_gnt", 32'(d_gnt), 32'd1);
        check("abort_idle_rw", 32'(mem_read_write), 32'd0);
        check("abort_reload", d_rdata, 32'h11AA_BEEF);
        next_cycle();
        set_d(1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
